gyruss_lpf_mux_ctrl: RTL
========================

// Module: gyruss_lpf_mux_ctrl
// PURPOSE
//  Time-multiplexed scheduler for the 1st-order IIR low-pass filter.
//  It runs one shared multiply-accumulate datapath across NCH audio channels (e.g. the per-chip AY outputs) instead of one filter instance per channel.
//  It contains the sample-rate divider, a per-channel sequencing FSM, per-channel state storage, output saturation and a frame-valid strobe.
//  It sits between the sound-chip mixers and the final audio mixer/DAC.
// PARAMETERS
//  NCH     5   number of channels filtered per sample tick (1..8)
//  CSHIFT  15  arithmetic right shift applied to the accumulator (coefficient Q-format)
// PORTS
//  clk        in   1       system clock (49.152 MHz)
//  reset      in   1       asynchronous reset, active-low (0 = reset)
//  div        in   10      sample divider; a tick fires every div clocks; 0 is treated as 1
//  A2         in   18      signed feedback coefficient, shared by all channels
//  B1         in   18      signed feed-forward coefficient applied to x[n]
//  B2         in   18      signed feed-forward coefficient applied to x[n-1]
//  bypass     in   NCH     per-channel bypass; when set, y = x
//  in         in   16*NCH  signed samples; channel k is in[16k+15:16k]
//  out        out  16*NCH  signed filtered samples, packed like in
//  out_valid  out  1       one-clock pulse when out has been updated
//  busy       out  1       FSM is not IDLE
//  overrun    out  1       sticky; a tick arrived while busy
// BEHAVIOUR
//  Reset (reset=0, async): cnt, ch, acc, all x_prev/y_prev, out, out_valid, busy and overrun are cleared to 0; FSM goes to IDLE.
//  Divider: cnt counts 0..max(div,1)-1. tick=1 in the cycle cnt==max(div,1)-1, and cnt then wraps to 0.
//    If div changes so that cnt >= the new limit, the next cycle wraps cnt to 0 and fires a tick.
//  Tick in IDLE: in, A2, B1, B2 and bypass are snapshotted, ch=0, FSM goes to MB1. Coefficient or input changes mid-frame are ignored.
//  Tick while busy: the tick is dropped, overrun is set to 1 (sticky until reset), and the frame in progress completes unchanged.
//  FSM: IDLE -> MB1 -> MB2 -> MA2 -> WR -> (ch<NCH-1 ? ch+1, MB1 : DONE) -> IDLE
//    MB1: acc  = B1 * x[ch]
//    MB2: acc += B2 * x_prev[ch]
//    MA2: acc -= A2 * y_prev[ch]
//    WR:  y_prev[ch] = bypass[ch] ? x[ch] : sat16(acc >>> CSHIFT); x_prev[ch] = x[ch]
//    DONE: out <= all y_prev, out_valid = 1 for this cycle only
//  Widths: products are 34-bit signed; acc is 36-bit signed with no internal overflow; shift is arithmetic.
//    sat16 clamps to [-32768, 32767].
//  Latency: out_valid is high exactly 4*NCH+1 cycles after the tick cycle (21 cycles for NCH=5).
//    Requires div >= 4*NCH+2, otherwise overrun occurs.
//  busy = (state != IDLE). It is high from the cycle after the tick through DONE, inclusive.
//  out holds its value between frames and is never partially updated.
//  Bypass still updates x_prev, so un-bypassing resumes without a step from stale history.
// TESTING
//  1 Reset: hold reset=0 with in driven nonzero -> out=0, out_valid=0, busy=0, overrun=0.
//    Release reset -> first tick after exactly div clocks.
//  2 Step: B1=B2=8192, A2=0, CSHIFT=15, all channels in=4000 -> frame 1 out=1000 each; frame 2 out=2000; steady at 2000.
//  3 Timing: NCH=5, div=220 -> out_valid pulses once per 220 clocks, 21 clocks after each tick.
//    busy is high for 21 cycles per frame.
//  4 Saturation: B1=B2=32767, A2=-32767, in=32767 -> out clamps at 32767 and never wraps.
//    Repeat with in=-32768 -> out clamps at -32768.
//  5 Bypass/overrun: bypass=5'b00100 -> ch2 out equals its in while other channels are filtered.
//    Set div=10 -> overrun=1 and stays 1; frames still complete with correct values.
//  6 Async reset mid-frame: assert reset=0 while in state MA2 -> all outputs and state are 0 immediately.
//    After release, frame 1 reproduces the results of scenario 2.

Source files
------------

// File: rtl/gyruss_lpf_mux_ctrl.sv
// gyruss_lpf_mux_ctrl: one shared MAC runs a 1st-order IIR
// low-pass over NCH packed audio channels per sample tick.
module gyruss_lpf_mux_ctrl #(
  parameter int NCH    = 5,
  parameter int CSHIFT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              div,
  input  logic signed [17:0]      A2,
  input  logic signed [17:0]      B1,
  input  logic signed [17:0]      B2,
  input  logic [NCH-1:0]          bypass,
  input  logic [16*NCH-1:0]       in,
  output logic [16*NCH-1:0]       out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [2:0] {
    IDLE, MB1, MB2, MA2, WR, DONE
  } state_t;

  state_t              state_q;
  logic [9:0]          cnt_q;
  logic [CW-1:0]       ch_q;
  logic signed [35:0]  acc_q;
  logic signed [15:0]  xs_q [NCH];
  logic signed [15:0]  xp_q [NCH];
  logic signed [15:0]  yp_q [NCH];
  logic signed [17:0]  a2_q, b1_q, b2_q;
  logic [NCH-1:0]      byp_q;
  logic [16*NCH-1:0]   out_q;
  logic                ov_q;
  logic                ovr_q;

  logic [9:0]          lim;
  logic                tick;
  logic signed [17:0]  c_m;
  logic signed [15:0]  s_m;
  logic signed [33:0]  prod;
  logic signed [35:0]  prod_x;
  logic signed [35:0]  sh;
  logic signed [15:0]  y_sat;
  logic signed [15:0]  y_new;

  // >= also catches a div shrink that leaves cnt past the limit
  assign lim  = (div == 10'd0) ? 10'd1 : div;
  assign tick = (cnt_q >= lim - 10'd1);

  always_comb begin
    c_m = b1_q;
    s_m = xs_q[ch_q];
    unique case (state_q)
      MB2: begin
        c_m = b2_q;
        s_m = xp_q[ch_q];
      end
      MA2: begin
        c_m = a2_q;
        s_m = yp_q[ch_q];
      end
      default: ;
    endcase
  end

  assign prod   = c_m * s_m;
  assign prod_x = {{2{prod[33]}}, prod};
  assign sh     = acc_q >>> CSHIFT;

  always_comb begin
    if (sh > 36'sd32767)
      y_sat = 16'sh7fff;
    else if (sh < -36'sd32768)
      y_sat = 16'sh8000;
    else
      y_sat = sh[15:0];
  end

  assign y_new = byp_q[ch_q] ? xs_q[ch_q] : y_sat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      acc_q   <= '0;
      a2_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      byp_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      ovr_q   <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        xs_q[k] <= '0;
        xp_q[k] <= '0;
        yp_q[k] <= '0;
      end
    end else begin
      cnt_q <= tick ? 10'd0 : cnt_q + 10'd1;
      ov_q  <= 1'b0;
      if (tick && state_q != IDLE)
        ovr_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (tick) begin
            for (int k = 0; k < NCH; k++)
              xs_q[k] <= in[16*k +: 16];
            a2_q    <= A2;
            b1_q    <= B1;
            b2_q    <= B2;
            byp_q   <= bypass;
            ch_q    <= '0;
            state_q <= MB1;
          end
        end
        MB1: begin
          acc_q   <= prod_x;
          state_q <= MB2;
        end
        MB2: begin
          acc_q   <= acc_q + prod_x;
          state_q <= MA2;
        end
        MA2: begin
          acc_q   <= acc_q - prod_x;
          state_q <= WR;
        end
        WR: begin
          yp_q[ch_q] <= y_new;
          xp_q[ch_q] <= xs_q[ch_q];
          if (ch_q == LAST) begin
            // publish all channels at once, last one bypassing the array
            for (int k = 0; k < NCH; k++)
              out_q[16*k +: 16] <= (k == NCH - 1) ? y_new : yp_q[k];
            ov_q    <= 1'b1;
            state_q <= DONE;
          end else begin
            ch_q    <= ch_q + 1'b1;
            state_q <= MB1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = ov_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = ovr_q;

endmodule
